// File: rtl/fpu_pkg.sv
// Shared FPU constants and types for the float-to-int conversion path.
package fpu_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] BIAS        = 8'd127;
  localparam logic [EXP_W-1:0] E_INT_LIMIT = 8'd158;
  localparam logic [EXP_W-1:0] E_HALF      = 8'd126;
  localparam logic [EXP_W-1:0] E_NO_SHIFT  = 8'd150;
  localparam logic [EXP_W-1:0] E_SPECIAL   = 8'd255;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic {
    FTOI_TRUNC = 1'b0,
    FTOI_RNA   = 1'b1
  } ftoi_mode_t;

  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_SMALL  = 3'd1,
    CLS_HALF   = 3'd2,
    CLS_BIG    = 3'd3,
    CLS_NAN    = 3'd4
  } ftoi_class_t;

endpackage

// File: rtl/ftoi_align.sv
// Classifies an FP32 exponent/mantissa and aligns the significand to an integer magnitude plus guard bit.
module ftoi_align
  import fpu_pkg::*;
(
  input  logic [EXP_W-1:0] e,
  input  logic [MAN_W-1:0] m,
  output logic [31:0]      mag,
  output logic             guard,
  output ftoi_class_t      cls
);

  logic [31:0] sig_s;
  logic [2:0]  lsh_s;
  logic [4:0]  rsh_s;

  // Classify the operand and shift the significand so its integer part lands in mag.
  always_comb begin
    sig_s = {8'd0, 1'b1, m};
    lsh_s = 3'(e - E_NO_SHIFT);
    rsh_s = 5'(E_NO_SHIFT - e);
    mag   = 32'd0;
    guard = 1'b0;
    cls   = CLS_NORMAL;
    if (e == E_SPECIAL && m != 23'd0) begin
      cls = CLS_NAN;
    end else if (e >= E_INT_LIMIT) begin
      // Only -2^31 is representable here; flag it through mag so stage 2 needs no extra state.
      cls = CLS_BIG;
      mag = (e == E_INT_LIMIT && m == 23'd0) ? INT32_MIN : 32'd0;
    end else if (e < E_HALF) begin
      cls = CLS_SMALL;
    end else if (e == E_HALF) begin
      cls = CLS_HALF;
    end else if (e >= E_NO_SHIFT) begin
      mag = sig_s << lsh_s;
    end else begin
      mag   = sig_s >> rsh_s;
      guard = sig_s[rsh_s - 5'd1];
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage FP32 to int32 converter (truncate or round-half-away) with valid/ready flow control.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter bit PIPE_BYPASS_S2 = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  logic        s1_valid_r;
  logic        s1_sign_r;
  logic        s1_guard_r;
  ftoi_mode_t  s1_mode_r;
  ftoi_class_t s1_cls_r;
  logic [31:0] s1_mag_r;
  logic        s1_adv_s;

  logic [31:0] al_mag_s;
  logic        al_guard_s;
  ftoi_class_t al_cls_s;

  logic [31:0] rnd_s;
  logic [31:0] res_y_s;
  logic        res_ovf_s;

  ftoi_align u_align (
    .e     (x[30:23]),
    .m     (x[22:0]),
    .mag   (al_mag_s),
    .guard (al_guard_s),
    .cls   (al_cls_s)
  );

  assign in_ready = s1_adv_s;

  // Stage 1 register: sign, mode, class and aligned magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_guard_r <= 1'b0;
      s1_mode_r  <= FTOI_TRUNC;
      s1_cls_r   <= CLS_SMALL;
      s1_mag_r   <= 32'd0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      s1_sign_r  <= x[31];
      s1_guard_r <= al_guard_s;
      s1_mode_r  <= ftoi_mode_t'(mode);
      s1_cls_r   <= al_cls_s;
      s1_mag_r   <= al_mag_s;
    end
  end

  // Stage 2 datapath: round, negate and saturate according to the operand class.
  always_comb begin
    rnd_s     = s1_mag_r + {31'd0, (s1_mode_r == FTOI_RNA) & s1_guard_r};
    res_y_s   = 32'd0;
    res_ovf_s = 1'b0;
    case (s1_cls_r)
      CLS_NORMAL: res_y_s = s1_sign_r ? (32'd0 - rnd_s) : rnd_s;
      CLS_SMALL:  res_y_s = 32'd0;
      CLS_HALF: begin
        if (s1_mode_r == FTOI_RNA) begin
          res_y_s = s1_sign_r ? 32'hFFFF_FFFF : 32'd1;
        end else begin
          res_y_s = 32'd0;
        end
      end
      CLS_BIG: begin
        if (s1_sign_r && s1_mag_r[31]) begin
          res_y_s = INT32_MIN;
        end else begin
          res_y_s   = s1_sign_r ? INT32_MIN : INT32_MAX;
          res_ovf_s = 1'b1;
        end
      end
      CLS_NAN: begin
        res_y_s   = INT32_MAX;
        res_ovf_s = 1'b1;
      end
      default: begin
        res_y_s   = 32'd0;
        res_ovf_s = 1'b0;
      end
    endcase
  end

  if (PIPE_BYPASS_S2) begin : g_bypass
    assign s1_adv_s  = !s1_valid_r || out_ready;
    assign out_valid = s1_valid_r;
    assign y         = res_y_s;
    assign ovf       = res_ovf_s;
  end else begin : g_reg
    logic        s2_valid_r;
    logic [31:0] s2_y_r;
    logic        s2_ovf_r;
    logic        s2_adv_s;

    assign s2_adv_s  = !s2_valid_r || out_ready;
    assign s1_adv_s  = !s1_valid_r || s2_adv_s;
    assign out_valid = s2_valid_r;
    assign y         = s2_y_r;
    assign ovf       = s2_ovf_r;

    // Stage 2 register: result holds while the consumer stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_r <= 1'b0;
        s2_y_r     <= 32'd0;
        s2_ovf_r   <= 1'b0;
      end else if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_y_r   <= res_y_s;
          s2_ovf_r <= res_ovf_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench for ftoi_pipe: directed vectors, stall stream, reset flush and random traffic.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  // entry = {x, ovf, y}
  logic [64:0] exp_q[$];

  localparam int NDIR = 18;
  localparam logic [31:0] DIR_X [NDIR] = '{
    32'h40200000, 32'h40200000, 32'hC0200000, 32'hC0200000, 32'hBF000000, 32'hBF000000,
    32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'h00000001, 32'h4B000001, 32'h4EFFFFFF,
    32'h3F000000, 32'h3FC00000, 32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h4B000001};
  localparam logic DIR_M [NDIR] = '{
    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [32:0] DIR_E [NDIR] = '{
    {1'b0, 32'h00000002}, {1'b0, 32'h00000003}, {1'b0, 32'hFFFFFFFE}, {1'b0, 32'hFFFFFFFD},
    {1'b0, 32'hFFFFFFFF}, {1'b0, 32'h00000000}, {1'b1, 32'h7FFFFFFF}, {1'b0, 32'h80000000},
    {1'b1, 32'h7FFFFFFF}, {1'b0, 32'h00000000}, {1'b0, 32'h00800001}, {1'b0, 32'h7FFFFF80},
    {1'b0, 32'h00000001}, {1'b0, 32'h00000002}, {1'b0, 32'h00000001}, {1'b1, 32'h7FFFFFFF},
    {1'b1, 32'h80000000}, {1'b0, 32'h00800001}};

  always #5 clk = ~clk;

  ftoi_pipe #(.PIPE_BYPASS_S2(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference: exact fixed-point value, truncated or rounded by adding one half, then saturated.
  function automatic logic [32:0] ref_ftoi(input logic [31:0] v, input logic md);
    logic         s;
    logic [7:0]   e;
    logic [22:0]  m;
    int           sh;
    logic [127:0] fx;
    logic [127:0] ip;
    s  = v[31];
    e  = v[30:23];
    m  = v[22:0];
    sh = int'(e) - 150;
    if (e == 8'hFF && m != 23'd0) return {1'b1, 32'h7FFFFFFF};
    if (e == 8'd0 || sh + 32 < 0) begin
      ip = 128'd0;
    end else if (sh > 8) begin
      ip = 128'h1_0000_0000;
    end else begin
      fx = {104'd0, 1'b1, m} << (sh + 32);
      ip = md ? ((fx + (128'd1 << 31)) >> 32) : (fx >> 32);
    end
    if (ip > 128'h7FFF_FFFF) begin
      if (s && ip == 128'h8000_0000) return {1'b0, 32'h80000000};
      return {1'b1, s ? 32'h80000000 : 32'h7FFFFFFF};
    end
    return {1'b0, s ? (32'd0 - ip[31:0]) : ip[31:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = 32'd0; mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 32'd0 || ovf !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_state got ov=%b y=%h ovf=%b ir=%b exp ov=0 y=0 ovf=0 ir=1",
               out_valid, y, ovf, in_ready);
    if (out_valid !== 1'b0 || y !== 32'd0 || ovf !== 1'b0 || in_ready !== 1'b1) errors++;
  endtask

  task automatic test_directed();
    logic [64:0] ent;
    for (int i = 0; i < NDIR; i++) begin
      @(negedge clk);
      x = DIR_X[i]; mode = DIR_M[i]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir_in_ready i=%0d got %b exp 1", i, in_ready);
      end
      exp_q.push_back({x, DIR_E[i]});
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir_latency_early i=%0d out_valid got %b exp 0", i, out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL dir_latency i=%0d out_valid got %b exp 1", i, out_valid);
        exp_q.delete();
      end else begin
        ent = exp_q.pop_front();
        if ({ovf, y} !== ent[32:0]) begin
          errors++;
          $display("FAIL dir_result x=%h mode=%b got ovf=%b y=%h exp ovf=%b y=%h",
                   ent[64:33], DIR_M[i], ovf, y, ent[32], ent[31:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [8] = '{32'h40200000, 32'hC0200000, 32'h3FC00000, 32'h4B000001,
                             32'hBF000000, 32'h42F70000, 32'hC2F70000, 32'h4E800001};
    logic [64:0] ent;
    logic [31:0] y_hold = 32'd0;
    logic        stalled_prev = 1'b0;
    logic        saw_block = 1'b0;
    logic        exp_rdy;
    int          sent = 0;
    int          got = 0;
    for (int k = 0; k < 40 && got < 8; k++) begin
      @(negedge clk);
      out_ready = !(k >= 3 && k < 6);
      in_valid  = (sent < 8);
      x         = (sent < 8) ? ops[sent] : 32'd0;
      mode      = sent[0];
      #1;
      exp_rdy = (exp_q.size() < 2) || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_in_ready k=%0d got %b exp %b", k, in_ready, exp_rdy);
      end
      if (!in_ready) saw_block = 1'b1;
      if (stalled_prev && out_valid) begin
        checks++;
        if (y !== y_hold) begin
          errors++;
          $display("FAIL b2b_stall_hold k=%0d got y=%h exp %h", k, y, y_hold);
        end
      end
      stalled_prev = out_valid && !out_ready;
      y_hold = y;
      if (out_valid && out_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got y=%h exp no output", y);
        end else begin
          ent = exp_q.pop_front();
          if ({ovf, y} !== ent[32:0]) begin
            errors++;
            $display("FAIL b2b_result x=%h got ovf=%b y=%h exp ovf=%b y=%h",
                     ent[64:33], ovf, y, ent[32], ent[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({x, ref_ftoi(x, mode)});
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 8", got);
    end
    checks++;
    if (!saw_block) begin
      errors++;
      $display("FAIL b2b_backpressure in_ready low got 0 times exp >=1");
    end
    exp_q.delete();
  endtask

  task automatic test_reset_flush();
    int waited = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; x = 32'h3F800000; mode = 1'b0;
    @(negedge clk);
    x = 32'h40400000;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_full got ov=%b ir=%b exp ov=1 ir=0", out_valid, in_ready);
    end
    rst = 1'b1; out_ready = 1'b1; x = 32'h40A00000;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 32'd0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got ov=%b y=%h ovf=%b ir=%b exp ov=0 y=0 ovf=0 ir=1",
               out_valid, y, ovf, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1; x = 32'h4B000001; mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (out_valid !== 1'b1 || y !== 32'h00800001 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL flush_next got ov=%b y=%h ovf=%b exp ov=1 y=00800001 ovf=0",
               out_valid, y, ovf);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_dup out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_random(input int n);
    logic [64:0] ent;
    logic [31:0] y_hold = 32'd0;
    logic        stalled_prev = 1'b0;
    logic        exp_rdy;
    logic [7:0]  e;
    logic [22:0] m;
    int          sent = 0;
    int          cyc = 0;
    int          bad = 0;
    while ((sent < n || exp_q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < n) && ($urandom_range(0, 4) != 0);
      e = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(120, 160)) : 8'($urandom_range(0, 255));
      m = 23'($urandom);
      if ($urandom_range(0, 3) == 0) m = m & 23'h7F0000;
      x    = {1'($urandom), e, m};
      mode = 1'($urandom);
      #1;
      exp_rdy = (exp_q.size() < 2) || out_ready;
      if (in_ready !== exp_rdy) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_in_ready cyc=%0d got %b exp %b", cyc, in_ready, exp_rdy);
      end
      checks++;
      if (stalled_prev && out_valid) begin
        checks++;
        if (y !== y_hold) begin
          errors++;
          if (bad++ < 10) $display("FAIL rand_stall_hold got y=%h exp %h", y, y_hold);
        end
      end
      stalled_prev = out_valid && !out_ready;
      y_hold = y;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          if (bad++ < 10) $display("FAIL rand_extra got y=%h exp no output", y);
        end else begin
          ent = exp_q.pop_front();
          if ({ovf, y} !== ent[32:0]) begin
            errors++;
            if (bad++ < 10)
              $display("FAIL rand_result x=%h got ovf=%b y=%h exp ovf=%b y=%h",
                       ent[64:33], ovf, y, ent[32], ent[31:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({x, ref_ftoi(x, mode)});
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || sent != n) begin
      errors++;
      $display("FAIL rand_timeout sent %0d of %0d, %0d outstanding exp 0", sent, n, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random(10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
